bram_c_readback_ctrl: RTL and testbench

Sequential reader for result BRAM C, on the read side of the C-port address/write-enable mux. On a start pulse it takes ownership of port A by asserting read_back_select. It then walks addresses 0..DEPTH-1, waits out the BRAM read latency, and presents each word with its address on a valid/ready stream to a downstream consumer (UART TX or display formatter). It releases the port when the scan ends.

---
 rtl/bram_c_pkg.sv | 16 +
 rtl/bram_c_readback_ctrl_if.sv | 46 ++++
 rtl/bram_c_readback_ctrl_rd_lat_counter.sv | 29 ++
 rtl/bram_c_readback_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_bram_c_readback_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_c_pkg.sv
// Shared definitions for the BRAM C address generators (read-back and write side).
package bram_c_pkg;

    localparam int unsigned BRAM_C_ADDR_W = 4;
    localparam int unsigned BRAM_C_DATA_W = 8;
    localparam int unsigned RD_LAT_CNT_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT,
        FINISH
    } bram_c_state_t;

endpackage

// File: rtl/bram_c_readback_ctrl_if.sv
// BRAM C port-A read side plus the valid/ready word stream toward the consumer.
interface bram_c_readback_ctrl_if
    import bram_c_pkg::*;
#(
    parameter int unsigned ADDR_W = BRAM_C_ADDR_W,
    parameter int unsigned DATA_W = BRAM_C_DATA_W
) ();

    logic              start;
    logic              read_back_select;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] douta;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start,
        input  douta,
        input  m_ready,
        output read_back_select,
        output addra,
        output m_data,
        output m_addr,
        output m_valid,
        output busy,
        output done
    );

    modport slave (
        output start,
        output douta,
        output m_ready,
        input  read_back_select,
        input  addra,
        input  m_data,
        input  m_addr,
        input  m_valid,
        input  busy,
        input  done
    );

endinterface

// File: rtl/bram_c_readback_ctrl_rd_lat_counter.sv
// Loadable down-counter that times the BRAM read latency; zero flag is combinational.
module rd_lat_counter
    import bram_c_pkg::*;
#(
    parameter int unsigned CNT_W = RD_LAT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/bram_c_readback_ctrl.sv
// Sequential BRAM C reader: owns port A during a scan and streams {addr, data} words.
// Optional continuous scanning is enabled with `define READBACK_LOOP_EN.
module bram_c_readback_ctrl
    import bram_c_pkg::*;
#(
    parameter int unsigned ADDR_W = BRAM_C_ADDR_W,
    parameter int unsigned DATA_W = BRAM_C_DATA_W,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned RD_LAT = 1
) (
    input logic                    clk,
    input logic                    rst,
    bram_c_readback_ctrl_if.master bus
);

    localparam logic [RD_LAT_CNT_W-1:0] LAT_LOAD  = RD_LAT_CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(DEPTH - 1);

    bram_c_state_t     r_state;
    logic              r_rbs;
    logic [ADDR_W-1:0] r_addra;
    logic [DATA_W-1:0] r_m_data;
    logic [ADDR_W-1:0] r_m_addr;
    logic              r_m_valid;
    logic              r_busy;
    logic              r_done;

    bram_c_state_t     w_state_nxt;
    logic              w_rbs_nxt;
    logic [ADDR_W-1:0] w_addra_nxt;
    logic [DATA_W-1:0] w_m_data_nxt;
    logic [ADDR_W-1:0] w_m_addr_nxt;
    logic              w_m_valid_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic              w_last;

`ifdef READBACK_LOOP_EN
    logic              r_stop;
    logic              w_stop_nxt;
`endif

    rd_lat_counter #(
        .CNT_W      (RD_LAT_CNT_W)
    ) u_rd_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (LAT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero_c   (w_cnt_zero)
    );

    assign w_last = (r_addra == LAST_ADDR);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rbs     <= 1'b0;
            r_addra   <= '0;
            r_m_data  <= '0;
            r_m_addr  <= '0;
            r_m_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rbs     <= w_rbs_nxt;
            r_addra   <= w_addra_nxt;
            r_m_data  <= w_m_data_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

`ifdef READBACK_LOOP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stop <= 1'b0;
        end else begin
            r_stop <= w_stop_nxt;
        end
    end
`endif

    // Next-state and next-output decode; done is a one-cycle pulse by default-clear
    always_comb begin
        w_state_nxt   = r_state;
        w_rbs_nxt     = r_rbs;
        w_addra_nxt   = r_addra;
        w_m_data_nxt  = r_m_data;
        w_m_addr_nxt  = r_m_addr;
        w_m_valid_nxt = r_m_valid;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_cnt_load    = 1'b0;
        w_cnt_dec     = 1'b0;
`ifdef READBACK_LOOP_EN
        w_stop_nxt    = r_stop;
`endif

        case (r_state)
            IDLE: begin
`ifdef READBACK_LOOP_EN
                w_stop_nxt = 1'b0;
`endif
                if (bus.start) begin
                    w_state_nxt = ISSUE;
                    w_rbs_nxt   = 1'b1;
                    w_addra_nxt = '0;
                    w_busy_nxt  = 1'b1;
                end
            end

            ISSUE: begin
`ifdef READBACK_LOOP_EN
                if (bus.start) w_stop_nxt = 1'b1;
`endif
                w_cnt_load  = 1'b1;
                w_state_nxt = WAIT;
            end

            WAIT: begin
`ifdef READBACK_LOOP_EN
                if (bus.start) w_stop_nxt = 1'b1;
`endif
                if (w_cnt_zero) begin
                    w_m_data_nxt  = bus.douta;
                    w_m_addr_nxt  = r_addra;
                    w_m_valid_nxt = 1'b1;
                    w_state_nxt   = PRESENT;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end

            PRESENT: begin
`ifdef READBACK_LOOP_EN
                if (bus.start) w_stop_nxt = 1'b1;
`endif
                if (bus.m_ready) begin
                    w_m_valid_nxt = 1'b0;
`ifdef READBACK_LOOP_EN
                    if (r_stop || bus.start) begin
                        w_state_nxt = FINISH;
                        w_rbs_nxt   = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else if (w_last) begin
                        w_done_nxt  = 1'b1;
                        w_addra_nxt = '0;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_addra_nxt = r_addra + ADDR_W'(1);
                        w_state_nxt = ISSUE;
                    end
`else
                    if (w_last) begin
                        w_state_nxt = FINISH;
                        w_rbs_nxt   = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_addra_nxt = r_addra + ADDR_W'(1);
                        w_state_nxt = ISSUE;
                    end
`endif
                end
            end

            FINISH: begin
`ifdef READBACK_LOOP_EN
                w_stop_nxt = 1'b0;
`endif
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.read_back_select = r_rbs;
    assign bus.addra            = r_addra;
    assign bus.m_data           = r_m_data;
    assign bus.m_addr           = r_m_addr;
    assign bus.m_valid          = r_m_valid;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;

endmodule

// File: tb/tb_bram_c_readback_ctrl.sv
// Bench for bram_c_readback_ctrl: stimulus tables, scoreboards and multi-cycle corner sequences.
module tb_bram_c_readback_ctrl;
    import bram_c_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    typedef struct {
        logic start;
        logic rdy;
        logic rbs;
        logic busy;
        logic vld;
        logic done;
        int   addra;
        int   maddr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    int            total = 0;
    int            bad   = 0;
    int            ncyc  = 0;
    int            hs1   = 0;
    int            done1 = 0;
    int            hs3   = 0;
    int            last3 = -1;
    exp_t          q1[$];
    exp_t          q3[$];
    exp_t          e1;
    exp_t          e3;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] p1;
    logic [DW-1:0] p2;
    vec_t          tv [6];

    always #5 clk = ~clk;

    bram_c_readback_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
    bram_c_readback_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

    bram_c_readback_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    bram_c_readback_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    // BRAM models with one and three cycles of read latency
    always @(posedge clk) if1.douta <= mem[if1.addra];
    always @(posedge clk) begin
        p1        <= mem[if3.addra];
        p2        <= p1;
        if3.douta <= p2;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    always @(negedge clk) ncyc++;

    // Handshakes are sampled after the bench has set m_ready for the coming edge
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (if1.m_valid && if1.m_ready) begin
                hs1++;
                if (q1.size() == 0) begin
                    chk("sb1_extra_word", 32'(if1.m_addr), 32'hFFFF);
                end else begin
                    e1 = q1.pop_front();
                    chk("sb1_addr", 32'(if1.m_addr), 32'(e1.a));
                    chk("sb1_data", 32'(if1.m_data), 32'(e1.d));
                end
            end
            if (if1.done) done1++;
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && if3.m_valid && if3.m_ready) begin
            hs3++;
            if (last3 >= 0) chk("lat3_word_spacing", 32'(ncyc - last3), 32'd5);
            last3 = ncyc;
            if (q3.size() == 0) begin
                chk("sb3_extra_word", 32'(if3.m_addr), 32'hFFFF);
            end else begin
                e3 = q3.pop_front();
                chk("sb3_addr", 32'(if3.m_addr), 32'(e3.a));
                chk("sb3_data", 32'(if3.m_data), 32'(e3.d));
            end
        end
    end

    task automatic push_scan(input bit which3);
        exp_t e;
        for (int i = 0; i < int'(DEPTH); i++) begin
            e.a = AW'(i);
            e.d = mem[i];
            if (which3) q3.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic start1();
        push_scan(1'b0);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
    endtask

    task automatic wait_word1(input int addr, input string nm);
        bit found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (if1.m_valid && (if1.m_addr == AW'(addr))) found = 1'b1;
            else @(negedge clk);
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    task automatic wait_addra1(input int addr, input string nm);
        bit found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (if1.addra == AW'(addr)) found = 1'b1;
            else @(negedge clk);
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    task automatic wait_done1(input string nm, output int prev_hs, output bit rbs_ok);
        bit found = 1'b0;
        prev_hs = hs1;
        rbs_ok  = 1'b1;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (if1.done) begin
                found = 1'b1;
            end else begin
                prev_hs = hs1;
                if (!if1.read_back_select) rbs_ok = 1'b0;
            end
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_hs;
        bit rbs_ok;
        int d;
        int h;
        int n;
        bit found;

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i * 3);
        rst = 1'b1;
        if1.start = 1'b0; if1.m_ready = 1'b0;
        if3.start = 1'b0; if3.m_ready = 1'b0;

        //            start rdy  rbs  busy vld  done addra maddr
        tv[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tv[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tv[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tv[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
        tv[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
        tv[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1};

        repeat (3) @(negedge clk);
        chk("rst_rbs",    32'(if1.read_back_select), 32'd0);
        chk("rst_addra",  32'(if1.addra),   32'd0);
        chk("rst_m_data", 32'(if1.m_data),  32'd0);
        chk("rst_m_addr", 32'(if1.m_addr),  32'd0);
        chk("rst_m_valid",32'(if1.m_valid), 32'd0);
        chk("rst_busy",   32'(if1.busy),    32'd0);
        chk("rst_done",   32'(if1.done),    32'd0);
        chk("rst3_busy",  32'(if3.busy),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Scan 1: opening cycles from the table, then run to completion
        push_scan(1'b0);
        for (int i = 0; i < 6; i++) begin
            if1.start   = tv[i].start;
            if1.m_ready = tv[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_rbs", i),    32'(if1.read_back_select), 32'(tv[i].rbs));
            chk($sformatf("vec%0d_busy", i),   32'(if1.busy),    32'(tv[i].busy));
            chk($sformatf("vec%0d_valid", i),  32'(if1.m_valid), 32'(tv[i].vld));
            chk($sformatf("vec%0d_done", i),   32'(if1.done),    32'(tv[i].done));
            chk($sformatf("vec%0d_addra", i),  32'(if1.addra),   32'(tv[i].addra));
            chk($sformatf("vec%0d_m_addr", i), 32'(if1.m_addr),  32'(tv[i].maddr));
        end
        if1.start = 1'b0;
        wait_done1("s1_done_seen", prev_hs, rbs_ok);
        chk("s1_hs_at_done",      32'(hs1), 32'd16);
        chk("s1_hs_before_done",  32'(prev_hs), 32'd15);
        chk("s1_rbs_during_scan", 32'(rbs_ok), 32'd1);
        chk("s1_rbs_at_done",     32'(if1.read_back_select), 32'd0);
        chk("s1_busy_at_done",    32'(if1.busy), 32'd0);
        @(negedge clk);
        chk("s1_done_pulse_width", 32'(if1.done), 32'd0);
        chk("s1_rbs_after",        32'(if1.read_back_select), 32'd0);
        chk("s1_done_count",       32'(done1), 32'd1);
        chk("s1_sb_empty",         32'(q1.size()), 32'd0);

        // Scan 2: ignored start at word 4, stall of five cycles on word 7
        start1();
        wait_word1(4, "s2_word4_seen");
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        wait_word1(7, "s2_word7_seen");
        if1.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("s2_stall%0d_valid", k),  32'(if1.m_valid), 32'd1);
            chk($sformatf("s2_stall%0d_data", k),   32'(if1.m_data),  32'd21);
            chk($sformatf("s2_stall%0d_m_addr", k), 32'(if1.m_addr),  32'd7);
            chk($sformatf("s2_stall%0d_addra", k),  32'(if1.addra),   32'd7);
        end
        if1.m_ready = 1'b1;
        wait_done1("s2_done_seen", prev_hs, rbs_ok);
        @(negedge clk);
        chk("s2_done_count", 32'(done1), 32'd2);
        chk("s2_hs_total",   32'(hs1), 32'd32);
        chk("s2_sb_empty",   32'(q1.size()), 32'd0);
        chk("s2_busy_after", 32'(if1.busy), 32'd0);

        // Scan 3: reset while waiting on word 9
        start1();
        wait_addra1(9, "s3_addr9_seen");
        @(negedge clk);
        chk("s3_in_wait_valid", 32'(if1.m_valid), 32'd0);
        d = done1;
        rst = 1'b1;
        @(negedge clk);
        chk("s3_rst_rbs",   32'(if1.read_back_select), 32'd0);
        chk("s3_rst_valid", 32'(if1.m_valid), 32'd0);
        chk("s3_rst_addra", 32'(if1.addra),   32'd0);
        chk("s3_rst_busy",  32'(if1.busy),    32'd0);
        chk("s3_rst_done",  32'(if1.done),    32'd0);
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("s3_no_done_after_rst", 32'(done1), 32'(d));

        // Scan 4: restart after reset begins again at address 0
        h = hs1;
        start1();
        wait_done1("s4_done_seen", prev_hs, rbs_ok);
        @(negedge clk);
        chk("s4_hs_count",   32'(hs1 - h), 32'd16);
        chk("s4_sb_empty",   32'(q1.size()), 32'd0);
        chk("s4_done_count", 32'(done1), 32'(d + 1));

        // RD_LAT=3 instance: first-word latency and five cycles per word
        push_scan(1'b1);
        if3.m_ready = 1'b1;
        if3.start   = 1'b1;
        @(negedge clk);
        if3.start = 1'b0;
        n = 1;
        while (!if3.m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("lat3_first_valid_cycle", 32'(n), 32'd5);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (if3.done) found = 1'b1;
        end
        chk("lat3_done_seen", 32'(found), 32'd1);
        chk("lat3_hs_count",  32'(hs3), 32'd16);
        chk("lat3_sb_empty",  32'(q3.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
